// File: rtl/conv_window_feeder_2x2_if.sv
// Pixel-stream input and window/tag output bundle of the 2x2 window feeder.
// The feeder uses the slave modport; the pixel source / conv core side uses master.
interface conv_window_feeder_2x2_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
);
  logic [7:0]                 pix_in;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [31:0]                image;
  logic                       win_valid;
  logic [$clog2(IMG_H)-1:0]   win_row;
  logic [$clog2(IMG_W)-1:0]   win_col;
  logic                       conv_valid;

  modport master (
    output pix_in, pix_valid,
    input  pix_ready, image, win_valid, win_row, win_col, conv_valid
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, image, win_valid, win_row, win_col, conv_valid
  );
endinterface

// File: rtl/conv_window_feeder_2x2.sv
// 2x2 sliding-window feeder: buffers one image row of a raster pixel stream,
// emits each stride-1 2x2 window as a packed 32-bit word for the conv core,
// and tags conv_out with a valid bit delayed by the core's latency.
module conv_window_feeder_2x2 #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int CONV_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  conv_window_feeder_2x2_if.slave pix_if,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(CONV_LAT + 1) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(CONV_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [7:0]          left_q, left_d;         // p(r, c-1)
  logic [7:0]          top_prev_q, top_prev_d; // p(r-1, c-1)
  logic [31:0]         image_q, image_d;
  logic                win_valid_q, win_valid_d;
  logic [RW-1:0]       win_row_q, win_row_d;
  logic [CW-1:0]       win_col_q, win_col_d;
  logic [CONV_LAT-1:0] cv_sr_q, cv_sr_d;

  logic [7:0] lb_mem [IMG_W];
  logic [7:0] lb_rd;
  logic       pix_ready_int;
  logic       accept;
  logic       last_pix;

  assign lb_rd    = lb_mem[col_q];
  assign accept   = pix_if.pix_valid && pix_ready_int;
  assign last_pix = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);

  // State register and datapath flops; everything visible resets to zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= '0;
      left_q      <= '0;
      top_prev_q  <= '0;
      image_q     <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      cv_sr_q     <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_cnt_q <= flush_cnt_d;
      left_q      <= left_d;
      top_prev_q  <= top_prev_d;
      image_q     <= image_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      cv_sr_q     <= cv_sr_d;
    end
  end

  // Line buffer: one slot per column, overwritten by the current row as the previous row is read.
  // NOTE: the RAM has no reset; every slot is written by row 0 before row 1 reads it.
  always_ff @(posedge clk) begin
    if (accept) lb_mem[col_q] <= pix_if.pix_in;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_pix) state_d = S_FLUSH;
      S_FLUSH: if (flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    pix_ready_int = (state_q == S_RUN);
    busy          = (state_q != S_IDLE);
    frame_done    = (state_q == S_DONE);
  end

  // Raster counters, window assembly, flush timer and conv_valid tag pipeline.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    left_d      = left_q;
    top_prev_d  = top_prev_q;
    image_d     = image_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = 1'b0;
    flush_cnt_d = (state_q == S_FLUSH) ? flush_cnt_q + FW'(1) : '0;

    if (state_q == S_IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end

    if (accept) begin
      left_d     = pix_if.pix_in;
      top_prev_d = lb_rd;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Only pixels with both an upper and a left neighbour complete a window.
      if (row_q != '0 && col_q != '0) begin
        image_d     = {top_prev_q, lb_rd, left_q, pix_if.pix_in};
        win_valid_d = 1'b1;
        win_row_d   = row_q;
        win_col_d   = col_q;
      end
    end

    // Tags keep shifting regardless of state so in-flight windows drain.
    cv_sr_d[0] = win_valid_q;
    for (int i = 1; i < CONV_LAT; i++) cv_sr_d[i] = cv_sr_q[i-1];
  end

  assign pix_if.pix_ready  = pix_ready_int;
  assign pix_if.image      = image_q;
  assign pix_if.win_valid  = win_valid_q;
  assign pix_if.win_row    = win_row_q;
  assign pix_if.win_col    = win_col_q;
  assign pix_if.conv_valid = cv_sr_q[CONV_LAT-1];

endmodule

// File: tb/tb_conv_window_feeder_2x2.sv
// Scoreboard bench for conv_window_feeder_2x2 on a 4x4 frame with a 2-cycle
// conv core model (filter 0x01010101) sitting on the image output.
module tb_conv_window_feeder_2x2;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int LAT = 2;
  localparam logic [31:0] FILTER = 32'h01010101;

  typedef struct {
    logic [31:0] img;
    int          r;
    int          c;
  } win_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic frame_done;

  conv_window_feeder_2x2_if #(.IMG_W(W), .IMG_H(H)) ifc ();

  conv_window_feeder_2x2 #(.IMG_W(W), .IMG_H(H), .CONV_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_if     (ifc.slave),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  win_t exp_q[$];
  int   conv_q[$];
  int   win_count   = 0;
  int   fd_count    = 0;
  bit   acc_prev    = 1'b0;

  function automatic logic [7:0] pv(input logic [7:0] seed, input int r, input int c);
    return seed + 8'(r * W + c + 1);
  endfunction

  function automatic int conv_of(input logic [31:0] img, input logic [31:0] f);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(img[8*i +: 8]) * int'(f[8*i +: 8]);
    return s;
  endfunction

  // Downstream conv core model: image in, conv_out two cycles later.
  logic [31:0] img_d1, img_d2;
  always @(posedge clk) begin
    img_d1 <= ifc.image;
    img_d2 <= img_d1;
  end

  // Output monitor: pops the scoreboard whenever the DUT presents a window or a conv tag.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
    end else begin
      if (ifc.win_valid) begin
        win_count++;
        vectors++;
        if (!acc_prev) begin
          miscompares++;
          $display("FAIL win_after_idle_cycle: win_valid=1 got, required 0 after non-accepting cycle");
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_window: image=%h got, no window expected", ifc.image);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          if (ifc.image !== e.img || int'(ifc.win_row) !== e.r || int'(ifc.win_col) !== e.c) begin
            miscompares++;
            $display("FAIL window: got %h @(%0d,%0d), required %h @(%0d,%0d)",
                     ifc.image, ifc.win_row, ifc.win_col, e.img, e.r, e.c);
          end
        end
      end
      if (ifc.conv_valid) begin
        vectors++;
        if (conv_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_conv_valid: conv_valid=1 got, required 0");
        end else begin
          int ev;
          ev = conv_q.pop_front();
          if (conv_of(img_d2, FILTER) !== ev) begin
            miscompares++;
            $display("FAIL conv_out: got %0d, required %0d", conv_of(img_d2, FILTER), ev);
          end
        end
      end
      if (frame_done) fd_count++;
      acc_prev = ifc.pix_valid && ifc.pix_ready;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one pixel, wait (bounded) for acceptance, then record its window if any.
  task automatic drive_pixel(input logic [7:0] seed, input int r, input int c);
    bit ok = 1'b0;
    int k  = 0;
    ifc.pix_in    = pv(seed, r, c);
    ifc.pix_valid = 1'b1;
    while (!ok && k < 50) begin
      @(negedge clk);
      if (ifc.pix_ready) ok = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    ifc.pix_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL pix_ready_timeout: pixel (%0d,%0d) not accepted within 50 cycles", r, c);
    end else if (r > 0 && c > 0) begin
      win_t e;
      e.img = {pv(seed, r-1, c-1), pv(seed, r-1, c), pv(seed, r, c-1), pv(seed, r, c)};
      e.r   = r;
      e.c   = c;
      exp_q.push_back(e);
      conv_q.push_back(int'(e.img[31:24]) + int'(e.img[23:16]) + int'(e.img[15:8]) + int'(e.img[7:0]));
    end
  endtask

  // Wait (bounded) for frame_done; optionally pulse start during the first FLUSH cycle.
  task automatic wait_done(input bit poke_flush);
    bit seen = 1'b0;
    int n    = 1;
    while (!seen && n <= 40) begin
      if (poke_flush && n == 1) start = 1'b1;
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        start = 1'b0;
        n++;
      end
    end
    start = 1'b0;
    vectors++;
    if (!seen || n != LAT + 2) begin
      miscompares++;
      $display("FAIL frame_done_latency: got %0d cycles (seen=%0b), required %0d", n, seen, LAT + 2);
    end
  endtask

  task automatic end_of_frame_checks();
    vectors++;
    if (win_count !== (H-1)*(W-1)) begin
      miscompares++;
      $display("FAIL window_count: got %0d, required %0d", win_count, (H-1)*(W-1));
    end
    vectors++;
    if (exp_q.size() != 0 || conv_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d windows / %0d tags left, required 0", exp_q.size(), conv_q.size());
    end
    vectors++;
    if (fd_count !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_end: frame_done pulses=%0d busy=%0b, required 1 and 0", fd_count, busy);
    end
  endtask

  task automatic run_frame(input logic [7:0] seed, input bit gaps, input bit poke);
    win_count = 0;
    fd_count  = 0;
    do_start();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive_pixel(seed, r, c);
        if (poke && r == 1 && c == 1) do_start();
        if (gaps && !(r == H-1 && c == W-1)) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_done(poke);
    @(posedge clk); #1;
    end_of_frame_checks();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.pix_ready, ifc.win_valid, ifc.conv_valid, busy, frame_done} !== 5'b0 ||
        ifc.image !== 32'h0 || ifc.win_row !== '0 || ifc.win_col !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ctl=%b image=%h row=%0d col=%0d, required all zero",
               {ifc.pix_ready, ifc.win_valid, ifc.conv_valid, busy, frame_done},
               ifc.image, ifc.win_row, ifc.win_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || ifc.pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_without_start: busy=%0b pix_ready=%0b, required 0 0", busy, ifc.pix_ready);
    end
  endtask

  task automatic test_basic();
    run_frame(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    run_frame(8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_frame(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    for (int k = 0; k < 6; k++) drive_pixel(8'h00, k / W, k % W);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifc.pix_ready, ifc.win_valid, ifc.conv_valid, busy, frame_done} !== 5'b0 ||
        ifc.image !== 32'h0 || ifc.win_row !== '0 || ifc.win_col !== '0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: ctl=%b image=%h row=%0d col=%0d, required all zero",
               {ifc.pix_ready, ifc.win_valid, ifc.conv_valid, busy, frame_done},
               ifc.image, ifc.win_row, ifc.win_col);
    end
    exp_q.delete();
    conv_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_row_wrap();
    win_count = 0;
    fd_count  = 0;
    do_start();
    for (int c = 0; c < W; c++) drive_pixel(8'h00, 0, c);
    drive_pixel(8'h00, 1, 0);
    @(negedge clk);
    vectors++;
    if (ifc.win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL row_wrap_no_window: win_valid=%0b, required 0", ifc.win_valid);
    end
    @(posedge clk); #1;
    drive_pixel(8'h00, 1, 1);
    @(negedge clk);
    vectors++;
    if (ifc.win_valid !== 1'b1 || ifc.image !== 32'h01020506 ||
        ifc.win_row !== 2'd1 || ifc.win_col !== 2'd1) begin
      miscompares++;
      $display("FAIL row_wrap_first_window: v=%0b image=%h (%0d,%0d), required 1 01020506 (1,1)",
               ifc.win_valid, ifc.image, ifc.win_row, ifc.win_col);
    end
    @(posedge clk); #1;
    for (int k = W + 2; k < W * H; k++) drive_pixel(8'h00, k / W, k % W);
    wait_done(1'b0);
    @(posedge clk); #1;
    end_of_frame_checks();
  endtask

  task automatic test_back_to_back();
    run_frame(8'h00, 1'b0, 1'b0);
    run_frame(8'h80, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    start         = 1'b0;
    ifc.pix_in    = 8'h00;
    ifc.pix_valid = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_start_ignored();
    test_reset_mid_frame();
    test_row_wrap();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
